neurotile_cfg_loader: RTL and testbench

// - Loads the neurotile configuration chain from a byte stream (ui_in side of the neurochip top).
// - Waits for a sync byte, then serialises CHAIN_BITS bits MSB-first onto the tile shift chain.
// - Pulses cfg_latch so the tiles copy the chain into their shadow registers.
// - Gates run_en so tiles stay frozen while a load is in progress.

---
 rtl/neurotile_pkg.sv | 21 ++
 rtl/neurotile_cfg_loader_piso.sv | 29 ++
 rtl/neurotile_cfg_loader.sv | 112 +++++++++++
 tb/tb_neurotile_cfg_loader.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neurotile_pkg.sv
// Shared types and defaults for the neurotile configuration loader.
package neurotile_pkg;

    localparam int unsigned CHAIN_BITS_DEF = 96;
    localparam logic [7:0]  SYNC_BYTE_DEF  = 8'hA5;
    localparam int unsigned CNT_W_DEF      = 12;

    function automatic int unsigned cfg_bytes(input int unsigned bits);
        return (bits + 7) / 8;
    endfunction

    localparam int unsigned CFG_BYTES = cfg_bytes(CHAIN_BITS_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        SHIFT = 2'd2,
        LATCH = 2'd3
    } state_t;

endpackage

// File: rtl/neurotile_cfg_loader_piso.sv
// 8-bit parallel-in serial-out register; bits leave MSB-first as bit_idx counts down.
module cfg_piso (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       shift,
    input  logic [7:0] din,
    output logic [2:0] bit_idx,
    output logic       next_bit
);

    logic [7:0] sreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg    <= 8'd0;
            bit_idx <= 3'd0;
        end else if (load) begin
            sreg    <= din;
            bit_idx <= 3'd7;
        end else if (shift) begin
            bit_idx <= bit_idx - 3'd1;
        end
    end

    // Bit that will be on the serial output in the following cycle.
    assign next_bit = load ? din[7] : sreg[3'(bit_idx - 3'd1)];

endmodule

// File: rtl/neurotile_cfg_loader.sv
// Byte-stream loader for the neurotile config chain: sync, serialise MSB-first, latch.
module neurotile_cfg_loader
    import neurotile_pkg::*;
#(
    parameter int unsigned CHAIN_BITS = CHAIN_BITS_DEF,
    parameter logic [7:0]  SYNC_BYTE  = SYNC_BYTE_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    input  logic       abort,
    output logic       cfg_sdo,
    output logic       cfg_shift,
    output logic       cfg_latch,
    output logic       run_en,
    output logic       busy,
    output logic       done
);

    state_t           state, state_next;
    logic [CNT_W-1:0] bit_cnt, cnt_next;
    logic             run_next, shift_next, sdo_next;
    logic             piso_load, piso_shift, next_bit;
    logic [2:0]       bit_idx;

    cfg_piso u_piso (
        .clk      (clk),
        .rst      (rst),
        .load     (piso_load),
        .shift    (piso_shift),
        .din      (byte_in),
        .bit_idx  (bit_idx),
        .next_bit (next_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            cfg_shift <= 1'b0;
            cfg_sdo   <= 1'b0;
            run_en    <= 1'b0;
        end else begin
            state     <= state_next;
            bit_cnt   <= cnt_next;
            cfg_shift <= shift_next;
            cfg_sdo   <= sdo_next;
            run_en    <= run_next;
        end
    end

    // cfg_shift/cfg_sdo are registered one cycle ahead so they line up with the SHIFT cycles.
    always_comb begin
        state_next = state;
        cnt_next   = bit_cnt;
        run_next   = run_en;
        shift_next = 1'b0;
        sdo_next   = 1'b0;
        piso_load  = 1'b0;
        piso_shift = 1'b0;
        case (state)
            IDLE: begin
                if (byte_valid && byte_in == SYNC_BYTE) begin
                    state_next = WAIT;
                    run_next   = 1'b0;
                    cnt_next   = '0;
                end
            end
            WAIT: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (byte_valid) begin
                    piso_load  = 1'b1;
                    state_next = SHIFT;
                    shift_next = 1'b1;
                    sdo_next   = next_bit;
                end
            end
            SHIFT: begin
                piso_shift = 1'b1;
                cnt_next   = bit_cnt + CNT_W'(1);
                if (abort) begin
                    state_next = IDLE;
                end else if (cnt_next == CNT_W'(CHAIN_BITS)) begin
                    state_next = LATCH;
                end else if (bit_idx == 3'd0) begin
                    state_next = WAIT;
                end else begin
                    shift_next = 1'b1;
                    sdo_next   = next_bit;
                end
            end
            LATCH: begin
                state_next = IDLE;
                if (!abort) begin
                    run_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Abort must be able to cancel the latch pulse in the LATCH cycle itself.
    assign cfg_latch  = (state == LATCH) && !abort;
    assign done       = (state == LATCH) && !abort;
    assign byte_ready = (state == IDLE) || ((state == WAIT) && !abort);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_neurotile_cfg_loader.sv
// Bench: two loaders (16- and 20-bit chains) checked against a byte-stream bit model.
module tb_neurotile_cfg_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] byte_in;
    logic       valid, abort, sel, clr;
    logic [1:0] valid_o, abort_o, ready_o, sdo_o, shift_o, latch_o, run_o, busy_o, done_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [63:0] sh_bits [2];
    logic [63:0] latch_bits [2];
    int          sh_cnt [2];
    int          last_sh [2];
    int          latch_cnt [2];
    int          done_cnt [2];
    int          latch_gap [2];
    int          latch_sh_cnt [2];
    logic        run_at_latch [2];
    int          viol [2];
    int          acc_q [$];

    always #5 clk = ~clk;

    assign valid_o = sel ? {valid, 1'b0} : {1'b0, valid};
    assign abort_o = sel ? {abort, 1'b0} : {1'b0, abort};

    neurotile_cfg_loader #(.CHAIN_BITS(16)) u16 (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(valid_o[0]),
        .byte_ready(ready_o[0]), .abort(abort_o[0]), .cfg_sdo(sdo_o[0]),
        .cfg_shift(shift_o[0]), .cfg_latch(latch_o[0]), .run_en(run_o[0]),
        .busy(busy_o[0]), .done(done_o[0])
    );

    neurotile_cfg_loader #(.CHAIN_BITS(20)) u20 (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(valid_o[1]),
        .byte_ready(ready_o[1]), .abort(abort_o[1]), .cfg_sdo(sdo_o[1]),
        .cfg_shift(shift_o[1]), .cfg_latch(latch_o[1]), .run_en(run_o[1]),
        .busy(busy_o[1]), .done(done_o[1])
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records the serial stream and latch events of each loader.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (clr) begin
                sh_bits[k]   <= '0;
                latch_bits[k] <= '0;
                sh_cnt[k]    <= 0;
                last_sh[k]   <= 0;
                latch_cnt[k] <= 0;
                done_cnt[k]  <= 0;
                latch_gap[k] <= 0;
                latch_sh_cnt[k] <= 0;
                run_at_latch[k] <= 1'b0;
                viol[k]      <= 0;
            end else begin
                if (shift_o[k]) begin
                    sh_bits[k] <= {sh_bits[k][62:0], sdo_o[k]};
                    sh_cnt[k]  <= sh_cnt[k] + 1;
                    last_sh[k] <= cyc;
                    if (ready_o[k]) viol[k] <= viol[k] + 1;
                end
                if (latch_o[k]) begin
                    latch_cnt[k]    <= latch_cnt[k] + 1;
                    latch_bits[k]   <= sh_bits[k];
                    latch_sh_cnt[k] <= sh_cnt[k];
                    latch_gap[k]    <= cyc - last_sh[k];
                    run_at_latch[k] <= run_o[k];
                end
                if (done_o[k]) done_cnt[k] <= done_cnt[k] + 1;
            end
        end
        if (clr) acc_q.delete();
        else if (valid_o[sel] && ready_o[sel]) acc_q.push_back(cyc);
    end

    // Reference: the chain receives the first n bits of the data bytes, MSB of first byte first.
    function automatic logic [63:0] exp_bits(input logic [63:0] data, input int nbytes, input int n);
        logic [63:0] m;
        m = (64'd1 << n) - 64'd1;
        return (data >> (8 * nbytes - n)) & m;
    endfunction

    function automatic logic [63:0] mask(input int n);
        return (64'd1 << n) - 64'd1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        clr = 1'b1;
        @(negedge clk);
        #1;
        clr = 1'b0;
        tick();
    endtask

    task automatic send(input logic [7:0] b);
        bit got;
        got = 1'b0;
        byte_in = b;
        valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ready_o[sel]) begin
                got = 1'b1;
                break;
            end
        end
        tick();
        valid = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL send_timeout: byte %h not accepted, ready=%b required 1", b, ready_o[sel]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b0; abort = 1'b0; byte_in = 8'h00; sel = 1'b0; clr = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({shift_o[k], sdo_o[k], latch_o[k], run_o[k], done_o[k]} !== 5'b0) begin
                errors++;
                $display("FAIL reset_outs[%0d]: got %b required 00000", k,
                         {shift_o[k], sdo_o[k], latch_o[k], run_o[k], done_o[k]});
            end
            checks++;
            if ({ready_o[k], busy_o[k]} !== 2'b10) begin
                errors++;
                $display("FAIL reset_ready_busy[%0d]: got %b required 10", k, {ready_o[k], busy_o[k]});
            end
        end
        rst = 1'b0;
        tick();
        clear();
    endtask

    task automatic test_discard();
        sel = 1'b0;
        clear();
        send(8'h3C);
        repeat (10) tick();
        checks++;
        if (busy_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL discard_busy: got %b required 0", busy_o[0]);
        end
        checks++;
        if (sh_cnt[0] !== 0) begin
            errors++;
            $display("FAIL discard_shift: got %0d shifts required 0", sh_cnt[0]);
        end
    endtask

    task automatic test_chain16();
        sel = 1'b0;
        clear();
        send(8'hA5);
        send(8'hC3);
        send(8'h5A);
        repeat (12) tick();
        checks++;
        if (latch_sh_cnt[0] !== 16 || (latch_bits[0] & mask(16)) !== exp_bits(64'hC35A, 2, 16)) begin
            errors++;
            $display("FAIL chain16_bits: got %0d bits %h required 16 bits %h", latch_sh_cnt[0],
                     latch_bits[0] & mask(16), exp_bits(64'hC35A, 2, 16));
        end
        checks++;
        if (latch_cnt[0] !== 1 || done_cnt[0] !== 1) begin
            errors++;
            $display("FAIL chain16_latch: latch=%0d done=%0d required 1 1", latch_cnt[0], done_cnt[0]);
        end
        checks++;
        if (latch_gap[0] !== 1 || run_at_latch[0] !== 1'b0) begin
            errors++;
            $display("FAIL chain16_timing: gap=%0d run_at_latch=%b required 1 0", latch_gap[0], run_at_latch[0]);
        end
        checks++;
        if (run_o[0] !== 1'b1 || busy_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL chain16_run: run=%b busy=%b required 1 0", run_o[0], busy_o[0]);
        end
    endtask

    task automatic test_chain20_pad();
        sel = 1'b1;
        clear();
        send(8'hA5);
        send(8'hFF);
        send(8'h00);
        send(8'hF0);
        repeat (12) tick();
        checks++;
        if (sh_cnt[1] !== 20 || (latch_bits[1] & mask(20)) !== exp_bits(64'hFF00F0, 3, 20)) begin
            errors++;
            $display("FAIL chain20_bits: got %0d bits %h required 20 bits %h", sh_cnt[1],
                     latch_bits[1] & mask(20), exp_bits(64'hFF00F0, 3, 20));
        end
        checks++;
        if (latch_cnt[1] !== 1 || latch_gap[1] !== 1 || run_o[1] !== 1'b1) begin
            errors++;
            $display("FAIL chain20_latch: latch=%0d gap=%0d run=%b required 1 1 1",
                     latch_cnt[1], latch_gap[1], run_o[1]);
        end
    endtask

    task automatic test_abort_shift();
        logic [7:0] b1, b2;
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        sel = 1'b1;
        clear();
        send(8'hA5);
        send(b1);
        send(b2);
        repeat (4) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (12) tick();
        checks++;
        if (sh_cnt[1] !== 13 || (sh_bits[1] & mask(13)) !== exp_bits({48'd0, b1, b2}, 2, 13)) begin
            errors++;
            $display("FAIL abort_shift_bits: got %0d bits %h required 13 bits %h", sh_cnt[1],
                     sh_bits[1] & mask(13), exp_bits({48'd0, b1, b2}, 2, 13));
        end
        checks++;
        if (latch_cnt[1] !== 0 || done_cnt[1] !== 0 || run_o[1] !== 1'b0 || busy_o[1] !== 1'b0) begin
            errors++;
            $display("FAIL abort_shift_state: latch=%0d done=%0d run=%b busy=%b required 0 0 0 0",
                     latch_cnt[1], done_cnt[1], run_o[1], busy_o[1]);
        end
    endtask

    task automatic test_abort_wait();
        sel = 1'b0;
        clear();
        send(8'hA5);
        byte_in = 8'($urandom);
        valid = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        checks++;
        if (ready_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL abort_wait_ready: got %b required 0", ready_o[0]);
        end
        tick();
        abort = 1'b0;
        valid = 1'b0;
        checks++;
        if (busy_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL abort_wait_busy: got %b required 0", busy_o[0]);
        end
        repeat (10) tick();
        checks++;
        if (sh_cnt[0] !== 0 || latch_cnt[0] !== 0) begin
            errors++;
            $display("FAIL abort_wait_shift: shifts=%0d latches=%0d required 0 0", sh_cnt[0], latch_cnt[0]);
        end
    endtask

    task automatic test_back_to_back();
        sel = 1'b1;
        clear();
        byte_in = 8'hA5;
        valid = 1'b1;
        repeat (30) tick();
        checks++;
        if (acc_q.size() < 4) begin
            errors++;
            $display("FAIL b2b_accepts: got %0d accepts required at least 4", acc_q.size());
        end else if (acc_q[1] - acc_q[0] !== 1 || acc_q[2] - acc_q[1] !== 9 || acc_q[3] - acc_q[2] !== 9) begin
            errors++;
            $display("FAIL b2b_spacing: gaps %0d %0d %0d required 1 9 9",
                     acc_q[1] - acc_q[0], acc_q[2] - acc_q[1], acc_q[3] - acc_q[2]);
        end
        checks++;
        if ((latch_bits[1] & mask(20)) !== exp_bits(64'hA5A5A5, 3, 20) || latch_cnt[1] !== 1) begin
            errors++;
            $display("FAIL b2b_bits: got %h latches=%0d required %h 1",
                     latch_bits[1] & mask(20), latch_cnt[1], exp_bits(64'hA5A5A5, 3, 20));
        end
        checks++;
        if (viol[1] !== 0) begin
            errors++;
            $display("FAIL b2b_ready_in_shift: got %0d cycles with ready during shift required 0", viol[1]);
        end
        checks++;
        if (shift_o[1] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_load: cfg_shift=%b required 1", shift_o[1]);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({shift_o[1], sdo_o[1], latch_o[1], run_o[1], done_o[1], busy_o[1], ready_o[1]} !== 7'b0000001) begin
            errors++;
            $display("FAIL b2b_rst: got %b required 0000001",
                     {shift_o[1], sdo_o[1], latch_o[1], run_o[1], done_o[1], busy_o[1], ready_o[1]});
        end
        rst = 1'b0;
        valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int n, nb, njunk;
            logic [63:0] data;
            logic [7:0]  b;
            sel = 1'($urandom_range(0, 1));
            n = sel ? 20 : 16;
            nb = (n + 7) / 8;
            data = '0;
            clear();
            njunk = $urandom_range(0, 2);
            for (int j = 0; j < njunk; j++) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h5A;
                send(b);
            end
            send(8'hA5);
            for (int j = 0; j < nb; j++) begin
                b = 8'($urandom);
                data = {data[55:0], b};
                repeat ($urandom_range(0, 3)) tick();
                send(b);
            end
            repeat (12) tick();
            checks++;
            if (latch_sh_cnt[sel] !== n || (latch_bits[sel] & mask(n)) !== exp_bits(data, nb, n)) begin
                errors++;
                $display("FAIL random_bits[%0d]: got %0d bits %h required %0d bits %h", it,
                         latch_sh_cnt[sel], latch_bits[sel] & mask(n), n, exp_bits(data, nb, n));
            end
            checks++;
            if (latch_cnt[sel] !== 1 || done_cnt[sel] !== 1 || run_o[sel] !== 1'b1) begin
                errors++;
                $display("FAIL random_latch[%0d]: latch=%0d done=%0d run=%b required 1 1 1", it,
                         latch_cnt[sel], done_cnt[sel], run_o[sel]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_discard();
        test_chain16();
        test_chain20_pad();
        test_abort_shift();
        test_abort_wait();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
